// File: rtl/int_pkg.sv
// Interrupt sequencer shared definitions: state encoding,
// default widths and sequencing constants.
package int_pkg;

  localparam int DATA_WIDTH_D  = 16;
  localparam int DATA_DEPTH_D  = 128;
  localparam int ADDR_WIDTH_D  = 16;
  localparam int STACK_DEPTH_D = 8;
  localparam int RET_TIMEOUT   = 16;
  localparam int SAVE_CYCLES   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_SAVE_GAP,
    S_JUMP,
    S_LOAD,
    S_RESUME
  } state_e;

endpackage

// File: rtl/int_seq.sv
// Interrupt entry/return sequencer: snapshots controller context
// to a context stack on entry and restores it on return.
module int_seq
  import int_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_D,
  parameter int DATA_DEPTH     = DATA_DEPTH_D,
  parameter int ADDR_WIDTH_MEM = ADDR_WIDTH_D,
  parameter int STACK_DEPTH    = STACK_DEPTH_D,
  parameter int RET_TIMEOUT    = int_pkg::RET_TIMEOUT,
  localparam int NW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      int_req,
  input  logic                      op_boundary,
  input  logic                      iret,
  input  logic [ADDR_WIDTH_MEM-1:0] isr_addr,
  input  logic [ADDR_WIDTH_MEM-1:0] cur_pc,
  input  logic [ADDR_WIDTH_MEM-1:0] cur_ctxt_addr,
  input  logic [DATA_WIDTH-1:0]     cur_bit_cnt,
  input  logic [DATA_WIDTH-1:0]     cur_mask,
  input  logic [2:0]                cur_pass,
  input  logic [DATA_DEPTH-1:0]     cur_C_F,
  output logic                      int_set,
  output logic                      ret_valid,
  output logic [ADDR_WIDTH_MEM-1:0] ret_addr,
  output logic [ADDR_WIDTH_MEM-1:0] ctxt_addr,
  output logic [DATA_WIDTH-1:0]     tmp_bit_cnt,
  output logic [DATA_WIDTH-1:0]     tmp_mask,
  output logic [2:0]                tmp_pass,
  output logic [DATA_DEPTH-1:0]     tmp_C_F,
  input  logic                      ctxt_rdy,
  input  logic [ADDR_WIDTH_MEM-1:0] ret_addr_ret,
  input  logic [ADDR_WIDTH_MEM-1:0] ctxt_addr_ret,
  input  logic [DATA_WIDTH-1:0]     tmp_bit_cnt_ret,
  input  logic [2:0]                tmp_pass_ret,
  input  logic [DATA_WIDTH-1:0]     tmp_mask_ret,
  input  logic [DATA_DEPTH-1:0]     tmp_C_F_ret,
  output logic                      hold,
  output logic                      jump_valid,
  output logic [ADDR_WIDTH_MEM-1:0] jump_addr,
  output logic                      int_ack,
  output logic                      restore_valid,
  output logic [ADDR_WIDTH_MEM-1:0] rs_pc,
  output logic [ADDR_WIDTH_MEM-1:0] rs_ctxt_addr,
  output logic [DATA_WIDTH-1:0]     rs_bit_cnt,
  output logic [2:0]                rs_pass,
  output logic [DATA_WIDTH-1:0]     rs_mask,
  output logic [DATA_DEPTH-1:0]     rs_C_F,
  output logic [NW-1:0]             nest_lvl,
  output logic                      unf_err,
  output logic                      tmo_err
);

  localparam int CW = $clog2(RET_TIMEOUT + SAVE_CYCLES + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   nest_q, nest_d;
  logic            unf_q, unf_d;
  logic            tmo_q, tmo_d;
  logic            latch, capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nest_d  = nest_q;
    unf_d   = unf_q;
    tmo_d   = tmo_q;
    latch   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (iret && nest_q != '0) begin
          state_d = S_LOAD;
        end else begin
          if (iret) unf_d = 1'b1;
          if (int_req && op_boundary &&
              nest_q < NW'(STACK_DEPTH)) begin
            latch   = 1'b1;
            state_d = S_SAVE;
          end
        end
      end
      S_SAVE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SAVE_CYCLES - 1)) begin
          state_d = S_SAVE_GAP;
        end
      end
      S_SAVE_GAP: state_d = S_JUMP;
      S_JUMP: begin
        nest_d  = nest_q + 1'b1;
        state_d = S_IDLE;
      end
      S_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (ctxt_rdy) begin
          capture = 1'b1;
          state_d = S_RESUME;
        end else if (cnt_q == CW'(RET_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESUME: begin
        nest_d  = nest_q - 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      nest_q       <= '0;
      unf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      ret_addr     <= '0;
      ctxt_addr    <= '0;
      tmp_bit_cnt  <= '0;
      tmp_mask     <= '0;
      tmp_pass     <= '0;
      tmp_C_F      <= '0;
      jump_addr    <= '0;
      rs_pc        <= '0;
      rs_ctxt_addr <= '0;
      rs_bit_cnt   <= '0;
      rs_pass      <= '0;
      rs_mask      <= '0;
      rs_C_F       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nest_q  <= nest_d;
      unf_q   <= unf_d;
      tmo_q   <= tmo_d;
      if (latch) begin
        ret_addr    <= cur_pc;
        ctxt_addr   <= cur_ctxt_addr;
        tmp_bit_cnt <= cur_bit_cnt;
        tmp_mask    <= cur_mask;
        tmp_pass    <= cur_pass;
        tmp_C_F     <= cur_C_F;
        jump_addr   <= isr_addr;
      end
      if (capture) begin
        rs_pc        <= ret_addr_ret;
        rs_ctxt_addr <= ctxt_addr_ret;
        rs_bit_cnt   <= tmp_bit_cnt_ret;
        rs_pass      <= tmp_pass_ret;
        rs_mask      <= tmp_mask_ret;
        rs_C_F       <= tmp_C_F_ret;
      end
    end
  end

  // Handshake outputs are pure state decodes, so reset clears them too.
  assign int_set       = (state_q == S_SAVE);
  assign jump_valid    = (state_q == S_JUMP);
  assign int_ack       = (state_q == S_JUMP);
  assign ret_valid     = (state_q == S_LOAD);
  assign restore_valid = (state_q == S_RESUME);
  assign hold          = (state_q != S_IDLE);
  assign nest_lvl      = nest_q;
  assign unf_err       = unf_q;
  assign tmo_err       = tmo_q;

endmodule

// File: tb/tb_int_seq.sv
// Directed self-checking bench for int_seq.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_int_seq;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DD = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          int_req = 1'b0, op_boundary = 1'b0, iret = 1'b0;
  logic [AW-1:0] isr_addr = '0, cur_pc = '0, cur_ctxt_addr = '0;
  logic [DW-1:0] cur_bit_cnt = '0, cur_mask = '0;
  logic [2:0]    cur_pass = '0;
  logic [DD-1:0] cur_C_F = '0;
  logic          int_set, ret_valid;
  logic [AW-1:0] ret_addr, ctxt_addr;
  logic [DW-1:0] tmp_bit_cnt, tmp_mask;
  logic [2:0]    tmp_pass;
  logic [DD-1:0] tmp_C_F;
  logic          ctxt_rdy = 1'b0;
  logic [AW-1:0] ret_addr_ret = '0, ctxt_addr_ret = '0;
  logic [DW-1:0] tmp_bit_cnt_ret = '0, tmp_mask_ret = '0;
  logic [2:0]    tmp_pass_ret = '0;
  logic [DD-1:0] tmp_C_F_ret = '0;
  logic          hold, jump_valid, int_ack, restore_valid;
  logic [AW-1:0] jump_addr, rs_pc, rs_ctxt_addr;
  logic [DW-1:0] rs_bit_cnt, rs_mask;
  logic [2:0]    rs_pass;
  logic [DD-1:0] rs_C_F;
  logic [3:0]    nest_lvl;
  logic          unf_err, tmo_err;

  int vectors = 0;
  int miscompares = 0;

  int_seq dut (
    .clk(clk), .rst(rst), .int_req(int_req),
    .op_boundary(op_boundary), .iret(iret),
    .isr_addr(isr_addr), .cur_pc(cur_pc),
    .cur_ctxt_addr(cur_ctxt_addr),
    .cur_bit_cnt(cur_bit_cnt), .cur_mask(cur_mask),
    .cur_pass(cur_pass), .cur_C_F(cur_C_F),
    .int_set(int_set), .ret_valid(ret_valid),
    .ret_addr(ret_addr), .ctxt_addr(ctxt_addr),
    .tmp_bit_cnt(tmp_bit_cnt), .tmp_mask(tmp_mask),
    .tmp_pass(tmp_pass), .tmp_C_F(tmp_C_F),
    .ctxt_rdy(ctxt_rdy), .ret_addr_ret(ret_addr_ret),
    .ctxt_addr_ret(ctxt_addr_ret),
    .tmp_bit_cnt_ret(tmp_bit_cnt_ret),
    .tmp_pass_ret(tmp_pass_ret),
    .tmp_mask_ret(tmp_mask_ret),
    .tmp_C_F_ret(tmp_C_F_ret),
    .hold(hold), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .int_ack(int_ack),
    .restore_valid(restore_valid),
    .rs_pc(rs_pc), .rs_ctxt_addr(rs_ctxt_addr),
    .rs_bit_cnt(rs_bit_cnt), .rs_pass(rs_pass),
    .rs_mask(rs_mask), .rs_C_F(rs_C_F),
    .nest_lvl(nest_lvl), .unf_err(unf_err),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full accept: C0 edge -> SAVE, SAVE, GAP, JUMP, back to IDLE.
  task automatic accept(input logic [AW-1:0] pc);
    cur_pc = pc;
    int_req = 1'b1;
    op_boundary = 1'b1;
    step();
    int_req = 1'b0;
    step(4);
  endtask

  initial begin
    step(2);
    chk("rst_hold", hold, 0);
    chk("rst_nest", nest_lvl, 0);
    chk("rst_intset", int_set, 0);
    chk("rst_errs", {unf_err, tmo_err}, 0);
    chk("rst_retaddr", ret_addr, 0);
    rst = 1'b1;
    step();

    // single interrupt
    cur_pc = 16'h0123; cur_ctxt_addr = 16'h0456;
    cur_mask = 16'hA5A5; cur_pass = 3'd5;
    cur_C_F = {8{16'hBEEF}};
    isr_addr = 16'h0800;
    int_req = 1'b1; op_boundary = 1'b1;
    step();
    int_req = 1'b0;
    chk("s1_intset", int_set, 1);
    chk("s1_hold", hold, 1);
    chk("s1_retaddr", ret_addr, 16'h0123);
    chk("s1_ctxt", ctxt_addr, 16'h0456);
    chk("s1_cf", tmp_C_F, {8{16'hBEEF}});
    iret = 1'b1;
    step();
    iret = 1'b0;
    cur_pc = 16'hFFFF;
    chk("s2_intset", int_set, 1);
    step();
    chk("gap_intset", int_set, 0);
    chk("gap_hold", hold, 1);
    step();
    chk("c4_jump", {jump_valid, int_ack}, 2'b11);
    chk("c4_jaddr", jump_addr, 16'h0800);
    chk("c4_nest", nest_lvl, 0);
    step();
    chk("post_jump", jump_valid, 0);
    chk("post_nest", nest_lvl, 1);
    chk("post_hold", hold, 0);
    chk("retaddr_held", ret_addr, 16'h0123);
    chk("iret_dropped", ret_valid, 0);

    // return
    iret = 1'b1;
    step();
    iret = 1'b0;
    chk("load_rv", ret_valid, 1);
    step();
    ctxt_rdy = 1'b1; ret_addr_ret = 16'h0123;
    tmp_pass_ret = 3'd5;
    step();
    ctxt_rdy = 1'b0;
    chk("resume_rsv", restore_valid, 1);
    chk("resume_rv", ret_valid, 0);
    chk("resume_pc", rs_pc, 16'h0123);
    chk("resume_pass", rs_pass, 3'd5);
    step();
    chk("ret_nest", nest_lvl, 0);
    chk("ret_rsv_off", restore_valid, 0);

    // underflow
    iret = 1'b1;
    step();
    iret = 1'b0;
    chk("unf_err", unf_err, 1);
    chk("unf_rv", ret_valid, 0);
    chk("unf_hold", hold, 0);

    // overflow
    for (int i = 0; i < 8; i++) accept(16'h1000 + 16'(i));
    chk("ovf_nest", nest_lvl, 8);
    int_req = 1'b1; op_boundary = 1'b1;
    step(3);
    chk("ovf_block", int_set, 0);
    chk("ovf_nohold", hold, 0);
    chk("ovf_noerr", {unf_err, tmo_err}, 2'b10);
    iret = 1'b1;
    step();
    iret = 1'b0;
    chk("ovf_iret_first", {ret_valid, int_set}, 2'b10);
    ctxt_rdy = 1'b1; ret_addr_ret = 16'h1007;
    step();
    ctxt_rdy = 1'b0;
    chk("ovf_rs_pc", rs_pc, 16'h1007);
    step();
    chk("ovf_nest7", nest_lvl, 7);
    step();
    int_req = 1'b0;
    chk("ovf_accept", int_set, 1);
    step(4);
    chk("ovf_nest8", nest_lvl, 8);

    // reset clears nest, then simultaneous at nest 1
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst2_nest", nest_lvl, 0);
    chk("rst2_unf", unf_err, 0);
    accept(16'h2222);
    chk("sim_nest1", nest_lvl, 1);
    int_req = 1'b1; iret = 1'b1;
    step();
    iret = 1'b0;
    chk("sim_load", {ret_valid, int_set}, 2'b10);
    ctxt_rdy = 1'b1; ret_addr_ret = 16'h0AAA;
    step();
    ctxt_rdy = 1'b0;
    chk("sim_rs_pc", rs_pc, 16'h0AAA);
    step();
    chk("sim_nest0", nest_lvl, 0);
    step();
    int_req = 1'b0;
    chk("sim_accept", int_set, 1);
    step(4);
    chk("sim_nest_end", nest_lvl, 1);

    // timeout
    iret = 1'b1;
    step();
    iret = 1'b0;
    step(15);
    chk("tmo_cyc16", {ret_valid, tmo_err}, 2'b10);
    step();
    chk("tmo_err", tmo_err, 1);
    chk("tmo_hold", hold, 0);
    chk("tmo_nest", nest_lvl, 1);
    chk("tmo_rsv", restore_valid, 0);

    // no op_boundary, then reset mid-SAVE
    int_req = 1'b1; op_boundary = 1'b0;
    step(2);
    chk("nob_wait", int_set, 0);
    op_boundary = 1'b1;
    step();
    int_req = 1'b0;
    chk("nob_save1", int_set, 1);
    step();
    chk("nob_save2", int_set, 1);
    rst = 1'b0;
    step();
    chk("mid_intset", int_set, 0);
    chk("mid_hold", hold, 0);
    chk("mid_nest", nest_lvl, 0);
    chk("mid_jump", jump_valid, 0);
    chk("mid_tmo", tmo_err, 0);
    rst = 1'b1;
    step();
    chk("mid_nojump", {jump_valid, hold}, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
